mux_arb_2to1: RTL and testbench
===============================

# mux_arb_2to1

Two-source arbitrating front end for the 8-bit 2:1 output mux stage. It accepts beats from two valid/ready sources (A and B) and picks one per cycle by round-robin or fixed priority. The winning beat goes into a single-entry output register. It presents the registered beat downstream with a matching `sel_o`: 1 means the beat came from A and 0 means from B, the same polarity the downstream mux uses for its select. Per-source saturating grant counters are provided for debug/performance visibility.

## Interface
- `DATA_W`, default 8, beat width.
- `CNT_W`, default 16, grant counter width.

- `clk`  in  1  clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous assert, active-low reset.
- `a_valid_i`  in  1  source A has a beat.
- `a_data_i`  in  DATA_W  source A beat.
- `a_ready_o`  out  1  A beat accepted this cycle when high with `a_valid_i`.
- `b_valid_i`  in  1  source B has a beat.
- `b_data_i`  in  DATA_W  source B beat.
- `b_ready_o`  out  1  B beat accepted this cycle when high with `b_valid_i`.
- `y_valid_o`  out  1  output register holds a beat.
- `y_data_o`  out  DATA_W  held beat.
- `y_ready_i`  in  1  downstream takes the beat.
- `sel_o`  out  1  source of the held beat (1 = A, 0 = B).
- `cnt_a_o`  out  CNT_W  A transfers since reset, saturating.
- `cnt_b_o`  out  CNT_W  B transfers since reset, saturating.

## Operation
- `load_en = !y_valid_o || y_ready_i`. The output register can take a new beat when it is empty or is being drained in the same cycle.
- Grant is combinational from the valids and the priority pointer `prio_a`:
  - Only one source valid: that source wins.
  - Both sources valid: A wins if `prio_a`=1, otherwise B wins.
- `a_ready_o = load_en && grant_a` and `b_ready_o = load_en && grant_b`. At most one ready is high in any cycle.
- A ready output may depend combinationally on `y_ready_i` and on both valids. No ready output depends on its own source's data.
- A transfer loads the output register as follows: `y_data_o` ← the winner's data, `sel_o` ← grant_a, `y_valid_o` ← 1.
- If `y_ready_i` is high and there is no new transfer, `y_valid_o` ← 0. `y_data_o` and `sel_o` keep their values.
- Priority pointer: on an A transfer `prio_a` ← 0; on a B transfer `prio_a` ← 1. With no transfer it holds.
- Grant counters: each counter increments by 1 on its source's transfer and holds at 2^CNT_W−1.
- Stall: while `y_valid_o && !y_ready_i`, `y_data_o` and `sel_o` stay stable and both readys are low.

## Timing
- Reset values: `y_valid_o`=0, `y_data_o`=0, `sel_o`=0, `prio_a`=1, `cnt_a_o`=0, `cnt_b_o`=0. `a_ready_o` and `b_ready_o` follow the combinational equations, so they go high after reset when the matching valid is asserted.
- Latency is 1 cycle: a beat accepted at edge N is visible on `y_*` after edge N.
- Throughput is 1 beat per cycle with `y_ready_i` held high. Simultaneous drain and load in one cycle is allowed and has no bubble.
- With both sources continuously valid and `y_ready_i`=1, the output sequence is A, B, A, B…, starting with A after reset.
- Reset asserted mid-operation clears state immediately and asynchronously. Any held beat is dropped and is not counted again. Deassertion is synchronised externally.

## Configuration
- `MUX_ARB_RR_EN` defined: round-robin arbitration, exactly as described in Operation.
- Not defined: fixed priority, A always wins when both sources are valid. `prio_a` is tied to 1 and not implemented as a flop. Everything else is unchanged.

## Test plan
- Reset, then A=0x11 valid alone, `y_ready_i`=1 → `a_ready_o`=1. The next cycle shows `y_valid_o`=1, `y_data_o`=0x11, `sel_o`=1, `cnt_a_o`=1.
- A streams 0xA0.. and B streams 0xB0.., both always valid, `y_ready_i`=1, RR enabled → outputs alternate 0xA0, 0xB0, 0xA1, 0xB1 and `sel_o` toggles 1,0,1,0. With the macro undefined → only 0xA0, 0xA1… appear and `b_ready_o` stays 0.
- Load 0x5A from B, then hold `y_ready_i`=0 for 5 cycles with both sources valid → `y_data_o`=0x5A, `sel_o`=0 and both readys stay 0 for all 5 cycles. Set `y_ready_i`=1 → 0x5A drains and A's beat loads in the same edge.
- Same-cycle drain and load over 20 cycles from B only → 20 beats arrive with no gaps, in order, and `cnt_b_o`=20.
- Assert `reset_n`=0 mid-stream while `y_valid_o`=1 → `y_valid_o`, the counters and `sel_o` go to 0 without waiting for a clock edge, and the next grant after release goes to A.
- CNT_W=4 with 20 A transfers → `cnt_a_o` stops at 15.

Source files
------------

// File: rtl/mux_arb_2to1.sv
// ============================================================================
// Module      : mux_arb_2to1
// Description : Two-source valid/ready arbiter feeding a single-entry output
//               register with source select and saturating grant counters.
//               Define MUX_ARB_RR_EN for round-robin; otherwise A has fixed
//               priority when both sources are valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arb_2to1 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    input  logic              y_ready_i,
    output logic              sel_o,
    output logic [CNT_W-1:0]  cnt_a_o,
    output logic [CNT_W-1:0]  cnt_b_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              y_valid_q, y_valid_d;
    logic [DATA_W-1:0] y_data_q,  y_data_d;
    logic              sel_q,     sel_d;
    logic [CNT_W-1:0]  cnt_a_q,   cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q,   cnt_b_d;

    logic load_en;
    logic prio_a;
    logic grant_a, grant_b;
    logic xfer_a,  xfer_b;

    assign load_en = !y_valid_q || y_ready_i;
    assign grant_a = a_valid_i && (!b_valid_i || prio_a);
    assign grant_b = b_valid_i && (!a_valid_i || !prio_a);
    assign xfer_a  = load_en && grant_a && a_valid_i;
    assign xfer_b  = load_en && grant_b && b_valid_i;

`ifdef MUX_ARB_RR_EN
    logic prio_a_q, prio_a_d;

    // The source that just won yields priority to the other one.
    always_comb begin
        prio_a_d = prio_a_q;
        if (xfer_a) begin
            prio_a_d = 1'b0;
        end else if (xfer_b) begin
            prio_a_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_a_q <= 1'b1;
        end else begin
            prio_a_q <= prio_a_d;
        end
    end

    assign prio_a = prio_a_q;
`else
    assign prio_a = 1'b1;
`endif

    always_comb begin
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        sel_d     = sel_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;

        if (xfer_a || xfer_b) begin
            y_valid_d = 1'b1;
            y_data_d  = xfer_a ? a_data_i : b_data_i;
            sel_d     = xfer_a;
        end else if (y_ready_i) begin
            y_valid_d = 1'b0;
        end

        if (xfer_a && (cnt_a_q != CNT_MAX)) begin
            cnt_a_d = cnt_a_q + 1'b1;
        end
        if (xfer_b && (cnt_b_q != CNT_MAX)) begin
            cnt_b_d = cnt_b_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            sel_q     <= 1'b0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
        end else begin
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            sel_q     <= sel_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
        end
    end

    assign a_ready_o = load_en && grant_a;
    assign b_ready_o = load_en && grant_b;
    assign y_valid_o = y_valid_q;
    assign y_data_o  = y_data_q;
    assign sel_o     = sel_q;
    assign cnt_a_o   = cnt_a_q;
    assign cnt_b_o   = cnt_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_2to1.sv
// ============================================================================
// Module      : tb_mux_arb_2to1
// Description : Directed, table-driven bench for mux_arb_2to1 (expectations
//               follow MUX_ARB_RR_EN if defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_arb_2to1;

`ifdef MUX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        a_valid, b_valid, y_ready;
    logic [7:0]  a_data, b_data;
    logic        a_ready, b_ready, y_valid, sel;
    logic [7:0]  y_data;
    logic [15:0] cnt_a, cnt_b;

    logic        s_a_ready, s_b_ready, s_y_valid, s_sel;
    logic [7:0]  s_y_data;
    logic [3:0]  s_cnt_a, s_cnt_b;

    int n_app  = 0;
    int n_miss = 0;

    mux_arb_2to1 #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_ready),
        .y_valid_o(y_valid), .y_data_o(y_data), .y_ready_i(y_ready),
        .sel_o(sel), .cnt_a_o(cnt_a), .cnt_b_o(cnt_b)
    );

    mux_arb_2to1 #(.DATA_W(8), .CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n),
        .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(s_a_ready),
        .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(s_b_ready),
        .y_valid_o(s_y_valid), .y_data_o(s_y_data), .y_ready_i(y_ready),
        .sel_o(s_sel), .cnt_a_o(s_cnt_a), .cnt_b_o(s_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [7:0]  ad;
        logic        bv;
        logic [7:0]  bd;
        logic        yr;
        logic        ea;
        logic        eb;
        logic        ev;
        logic [7:0]  ed;
        logic        es;
        logic [15:0] eca;
        logic [15:0] ecb;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_app++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [7:0] ad, input logic bv,
                         input logic [7:0] bd, input logic yr);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        reset_n = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic       exp_prio;
        logic       exp_a;
        int         ia, ib;
        logic [7:0] exp_d;

        reset_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Expected values hand-computed; entries 6/7 differ with arbitration mode.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 16'd1, 16'd0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 16'd1, 16'd1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 16'd1, 16'd1};
        tbl[3] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 16'd1, 16'd1};
        tbl[4] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 16'd2, 16'd1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 16'd2, 16'd1};
        tbl[6] = '{1'b1, 8'h44, 1'b1, 8'h55, 1'b0, !RR, RR, 1'b1,
                   RR ? 8'h55 : 8'h44, !RR, RR ? 16'd2 : 16'd3, RR ? 16'd2 : 16'd1};
        tbl[7] = '{1'b1, 8'h66, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 1'b1,
                   RR ? 16'd3 : 16'd4, RR ? 16'd2 : 16'd1};

        #2;
        chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
        chk("rst_y_data",  {24'd0, y_data}, 32'd0);
        chk("rst_sel",     {31'd0, sel}, 32'd0);
        chk("rst_cnt_a",   {16'd0, cnt_a}, 32'd0);
        chk("rst_cnt_b",   {16'd0, cnt_b}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].yr);
            #1;
            chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, tbl[i].ea});
            chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, tbl[i].eb});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_y_valid", i), {31'd0, y_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("v%0d_y_data", i),  {24'd0, y_data},  {24'd0, tbl[i].ed});
            chk($sformatf("v%0d_sel", i),     {31'd0, sel},     {31'd0, tbl[i].es});
            chk($sformatf("v%0d_cnt_a", i),   {16'd0, cnt_a},   {16'd0, tbl[i].eca});
            chk($sformatf("v%0d_cnt_b", i),   {16'd0, cnt_b},   {16'd0, tbl[i].ecb});
        end

        // ---------------- both sources streaming ----------------
        do_reset();
        exp_prio = 1'b1;
        ia = 0;
        ib = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, 8'hA0 + 8'(ia), 1'b1, 8'hB0 + 8'(ib), 1'b1);
            exp_a = RR ? exp_prio : 1'b1;
            exp_d = exp_a ? 8'hA0 + 8'(ia) : 8'hB0 + 8'(ib);
            #1;
            chk($sformatf("alt%0d_a_ready", i), {31'd0, a_ready}, {31'd0, exp_a});
            chk($sformatf("alt%0d_b_ready", i), {31'd0, b_ready}, {31'd0, !exp_a});
            @(posedge clk);
            #1;
            chk($sformatf("alt%0d_y_data", i), {24'd0, y_data}, {24'd0, exp_d});
            chk($sformatf("alt%0d_sel", i),    {31'd0, sel},    {31'd0, exp_a});
            if (exp_a) ia++; else ib++;
            exp_prio = !exp_a;
        end

        // ---------------- stall holds beat ----------------
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);
        @(posedge clk);
        #1;
        chk("stall_load", {24'd0, y_data}, 32'h5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 8'hC3, 1'b1, 8'hD4, 1'b0);
            #1;
            chk($sformatf("stall%0d_readys", i), {30'd0, a_ready, b_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_y", i), {22'd0, y_valid, sel, y_data}, {22'd0, 1'b1, 1'b0, 8'h5A});
        end
        @(negedge clk);
        y_ready = 1'b1;
        #1;
        chk("unstall_a_ready", {30'd0, a_ready, b_ready}, 32'd2);
        @(posedge clk);
        #1;
        chk("unstall_y", {22'd0, y_valid, sel, y_data}, {22'd0, 1'b1, 1'b1, 8'hC3});

        // ---------------- 20 back-to-back beats from B ----------------
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'(i), 1'b1);
            #1;
            chk($sformatf("bstr%0d_b_ready", i), {31'd0, b_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("bstr%0d_y", i), {23'd0, y_valid, y_data}, {23'd0, 1'b1, 8'(i)});
            @(negedge clk);
        end
        b_valid = 1'b0;
        chk("bstr_cnt_b", {16'd0, cnt_b}, 32'd20);

        // ---------------- counter saturation on CNT_W=4 ----------------
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'h80 + 8'(i), 1'b0, 8'h00, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        a_valid = 1'b0;
        y_ready = 1'b0;
        chk("sat_small_cnt_a", {28'd0, s_cnt_a}, 32'd15);
        chk("sat_cnt_a",       {16'd0, cnt_a},   32'd20);

        // ---------------- asynchronous reset mid-stream ----------------
        chk("pre_rst_y", {30'd0, y_valid, sel}, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_y_valid", {31'd0, y_valid}, 32'd0);
        chk("arst_sel",     {31'd0, sel}, 32'd0);
        chk("arst_cnt",     {cnt_a, cnt_b}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 8'hE1, 1'b1, 8'hE2, 1'b1);
        #1;
        chk("arst_grant", {30'd0, a_ready, b_ready}, 32'd2);
        @(posedge clk);
        #1;
        chk("arst_first_y", {23'd0, sel, y_data}, {23'd0, 1'b1, 8'hE1});
        chk("arst_cnt_a",   {16'd0, cnt_a}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
